// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, requester IDs, access-size codes, latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Requester identifiers; IF is the reset owner and the reset last-grant value.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Access size codes as carried on DmBHW / MemBHW.
    localparam logic [1:0] BHW_BYTE = 2'd0;
    localparam logic [1:0] BHW_HALF = 2'd1;
    localparam logic [1:0] BHW_WORD = 2'd2;

    // Latency counter holds up to MEM_LATENCY-1 = 14.
    localparam int CNT_W = 4;

    // The requester that is not 'id'.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between fetch and data requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: if_req_i/dm_req_i request levels, last_i last granted ID (round-robin
// build only), vld_o any request present, pick_o winning requester ID.
// Macro ARB_ROUND_ROBIN_EN selects alternating tie-breaking; otherwise data wins.
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic vld_o,
    output logic pick_o
);

    always_comb begin
        vld_o  = if_req_i | dm_req_i;
        pick_o = REQ_IF;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie, the requester that was not granted last goes next.
        if (if_req_i && dm_req_i) begin
            pick_o = other_req(last_i);
        end else if (dm_req_i) begin
            pick_o = REQ_DM;
        end
`else
        if (dm_req_i) begin
            pick_o = REQ_DM;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data paths.
// Latency: Req in cycle 0 -> MemEn cycle 1 -> Done cycle 2+MEM_LATENCY.
// Backpressure: level Req held until Done; Stall freezes the core meanwhile.
// Ports: Clk/Reset (async, active-high); IfReq/IfAddr/IfRdata/IfDone fetch side;
// DmReq/DmWrite/DmAddr/DmWdata/DmBHW/DmRdata/DmDone data side;
// MemEn/MemWrite/MemAddr/MemWdata/MemBHW/MemRdata memory macro side; Stall to core.
// Macro ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (default: data wins).
// MEM_LATENCY legal range 1..15.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfRdata,
    output logic              IfDone,
    input  logic              DmReq,
    input  logic              DmWrite,
    input  logic [ADDR_W-1:0] DmAddr,
    input  logic [DATA_W-1:0] DmWdata,
    input  logic [1:0]        DmBHW,
    output logic [DATA_W-1:0] DmRdata,
    output logic              DmDone,
    output logic              MemEn,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    output logic [1:0]        MemBHW,
    input  logic [DATA_W-1:0] MemRdata,
    output logic              Stall
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              owner_q,     owner_d;
    logic              op_wr_q,     op_wr_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_bhw_q,   mem_bhw_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              dm_done_q,   dm_done_d;

    logic              pick_vld;
    logic              pick_id;
    logic              grant;
    logic              grant_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .last_i   (last_q),
`endif
        .if_req_i (IfReq),
        .dm_req_i (DmReq),
        .vld_o    (pick_vld),
        .pick_o   (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        op_wr_d     = op_wr_q;
        mem_en_d    = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bhw_d   = mem_bhw_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        grant       = 1'b0;
        grant_id    = REQ_IF;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant    = 1'b1;
                    grant_id = pick_id;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Read data is valid this cycle; stores leave Rdata untouched.
                    if (!op_wr_q) begin
                        if (owner_q == REQ_DM) begin
                            dm_rdata_d = MemRdata;
                        end else begin
                            if_rdata_d = MemRdata;
                        end
                    end
                    if (owner_q == REQ_DM) begin
                        dm_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // The owner is still holding Req during its Done cycle, so only
                // the other requester can be granted straight from here.
                state_d = IDLE;
                if ((owner_q == REQ_DM) ? IfReq : DmReq) begin
                    grant    = 1'b1;
                    grant_id = other_req(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d  = ISSUE;
            owner_d  = grant_id;
            mem_en_d = 1'b1;
            if (grant_id == REQ_DM) begin
                op_wr_d     = DmWrite;
                mem_write_d = DmWrite;
                mem_addr_d  = DmAddr;
                mem_wdata_d = DmWdata;
                mem_bhw_d   = DmBHW;
            end else begin
                // Fetch is always a word read; write data is left as it was.
                op_wr_d    = 1'b0;
                mem_addr_d = IfAddr;
                mem_bhw_d  = BHW_WORD;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign last_d = grant ? grant_id : last_q;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_IF;
            op_wr_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bhw_q   <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= REQ_IF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            op_wr_q     <= op_wr_d;
            mem_en_q    <= mem_en_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bhw_q   <= mem_bhw_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign MemEn    = mem_en_q;
    assign MemWrite = mem_write_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign MemBHW   = mem_bhw_q;
    assign IfRdata  = if_rdata_q;
    assign DmRdata  = dm_rdata_q;
    assign IfDone   = if_done_q;
    assign DmDone   = dm_done_q;

    // Combinational so the core freezes in the very cycle a request appears.
    assign Stall = ~Reset & ((IfReq & ~if_done_q) | (DmReq & ~dm_done_q));

endmodule
